// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: request side (A/B/opcode),
// response side (result/flags) and the sticky-overflow controls.
interface alu_seq_if #(
  parameter int N = 4
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   aluc;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         out_valid;
  logic         out_ready;
  logic         sticky_v;
  logic         clr_sticky;

  modport master (
    output a, b, aluc, in_valid, out_ready, clr_sticky,
    input  in_ready, result, flags, out_valid, sticky_v
  );

  modport slave (
    input  a, b, aluc, in_valid, out_ready, clr_sticky,
    output in_ready, result, flags, out_valid, sticky_v
  );
endinterface

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked N-bit ALU with an iterative shift-add
// multiplier and a sticky overflow flag. flags = {NEG, ZERO, CARRY, OVF}.
module alu_seq #(
  parameter int N = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic           out_valid_q, out_valid_d;
  logic           sticky_q, sticky_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           in_ready_s, accept_s, is_mul_s, mul_last_s;
  logic [N:0]     add_s, sub_s;
  logic           add_v_s, sub_v_s;
  logic [N-1:0]   alu_res_s;
  logic           alu_c_s, alu_v_s;
  logic [3:0]     alu_flags_s, mul_flags_s;
  logic [2*N-1:0] acc_step_s;

  assign in_ready_s = (state_q == S_IDLE) | ((state_q == S_HOLD) & bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign is_mul_s   = (bus.aluc == OP_MUL);
  assign mul_last_s = (state_q == S_MUL) && (cnt_q == CW'(N - 1));

  // SUB is A + ~B + 1, so CARRY=1 means no borrow.
  assign add_s   = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_s   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
  assign add_v_s = (bus.a[N-1] == bus.b[N-1]) & (add_s[N-1] != bus.a[N-1]);
  assign sub_v_s = (bus.a[N-1] != bus.b[N-1]) & (sub_s[N-1] != bus.a[N-1]);

  assign acc_step_s  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_flags_s = {acc_step_s[N-1], (acc_step_s[N-1:0] == {N{1'b0}}),
                        |acc_step_s[2*N-1:N], 1'b0};

  // Single-cycle op result; for CMP this is the subtraction value the flags use.
  always_comb begin
    alu_res_s = {N{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.aluc)
      OP_ADD: begin
        alu_res_s = add_s[N-1:0];
        alu_c_s   = add_s[N];
        alu_v_s   = add_v_s;
      end
      OP_SUB, OP_CMP: begin
        alu_res_s = sub_s[N-1:0];
        alu_c_s   = sub_s[N];
        alu_v_s   = sub_v_s;
      end
      OP_AND: alu_res_s = bus.a & bus.b;
      OP_OR:  alu_res_s = bus.a | bus.b;
      OP_XOR: alu_res_s = bus.a ^ bus.b;
      OP_SLT: begin
        alu_res_s = {{(N-1){1'b0}}, sub_s[N-1] ^ sub_v_s};
        alu_c_s   = sub_s[N];
        alu_v_s   = sub_v_s;
      end
      OP_MUL: alu_res_s = {N{1'b0}};
      default: alu_res_s = {N{1'b0}};
    endcase
    alu_flags_s = {alu_res_s[N-1], (alu_res_s == {N{1'b0}}), alu_c_s, alu_v_s};
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = is_mul_s ? S_MUL : S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_last_s) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_MUL;
        end
      end
      S_HOLD: begin
        if (accept_s) begin
          state_d = is_mul_s ? S_MUL : S_HOLD;
        end else if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and multiplier datapath next values; a set of STICKY_V beats a clear.
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q & ~bus.clr_sticky;
    if (accept_s) begin
      if (is_mul_s) begin
        mcand_d     = {{N{1'b0}}, bus.a};
        mplier_d    = bus.b;
        acc_d       = {(2*N){1'b0}};
        cnt_d       = {CW{1'b0}};
        out_valid_d = 1'b0;
      end else begin
        result_d    = (bus.aluc == OP_CMP) ? result_q : alu_res_s;
        flags_d     = alu_flags_s;
        out_valid_d = 1'b1;
        sticky_d    = (sticky_q & ~bus.clr_sticky) | alu_v_s;
      end
    end else if (state_q == S_MUL) begin
      acc_d    = acc_step_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (mul_last_s) begin
        result_d    = acc_step_s[N-1:0];
        flags_d     = mul_flags_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if ((state_q == S_HOLD) && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q    <= {N{1'b0}};
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= {(2*N){1'b0}};
      mcand_q     <= {(2*N){1'b0}};
      mplier_q    <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sticky_v  = sticky_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random traffic,
// all compared against an arithmetic reference model and a latency model.
module tb_alu_seq;
  localparam int N = 4;
  localparam bit [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam bit [2:0] XOR_ = 3'd4, SLT = 3'd5, MUL = 3'd6, CMP = 3'd7;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_seq_if #(.N(N)) bus ();
  alu_seq #(.N(N)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: one op in flight at most, edges left until valid.
  bit       m_has_op;
  int       m_wait;
  bit [3:0] m_res;
  bit [3:0] m_flags;
  bit [3:0] m_last_res;
  bit       m_sticky;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Returns {result, flags} from plain integer arithmetic.
  function automatic bit [7:0] ref_op(input bit [2:0] op, input bit [3:0] a,
                                      input bit [3:0] b, input bit [3:0] prev);
    int ua, ub, sa, sb, r, sr;
    bit c, v;
    bit [3:0] val, res;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      ADD: begin r = ua + ub; sr = sa + sb; c = (r > 15); v = (sr > 7) || (sr < -8); end
      SUB, CMP, SLT: begin r = ua - ub; sr = sa - sb; c = (ua >= ub); v = (sr > 7) || (sr < -8); end
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      MUL:  begin r = ua * ub; c = (r > 15); end
      default: r = 0;
    endcase
    val = r[3:0];
    if (op == SLT) val = (sa < sb) ? 4'd1 : 4'd0;
    res = (op == CMP) ? prev : val;
    return {res, val[3], (val == 4'd0), c, v};
  endfunction

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input bit iv, input bit [2:0] op, input bit [3:0] a, input bit [3:0] b,
                      input bit ordy, input bit clr);
    bit exp_ov, exp_ir, acc;
    bit [7:0] rf;
    bus.in_valid = iv; bus.aluc = op; bus.a = a; bus.b = b;
    bus.out_ready = ordy; bus.clr_sticky = clr;
    #1;
    exp_ov = m_has_op && (m_wait == 0);
    exp_ir = !m_has_op || (exp_ov && ordy);
    check_val("out_valid", bus.out_valid, exp_ov);
    check_val("in_ready", bus.in_ready, exp_ir);
    check_val("sticky_v", bus.sticky_v, m_sticky);
    if (exp_ov) begin
      check_val("result", bus.result, m_res);
      check_val("flags", bus.flags, m_flags);
    end
    acc = iv && exp_ir;
    @(posedge clk);
    if (exp_ov && ordy) m_has_op = 1'b0;
    if (clr) m_sticky = 1'b0;
    if (acc) begin
      rf = ref_op(op, a, b, m_last_res);
      m_res = rf[7:4];
      m_flags = rf[3:0];
      m_last_res = m_res;
      m_has_op = 1'b1;
      m_wait = (op == MUL) ? N : 0;
      if (m_flags[0]) m_sticky = 1'b1;
    end else if (m_has_op && m_wait > 0) begin
      m_wait--;
    end
    #1;
  endtask

  task automatic model_reset();
    m_has_op = 1'b0; m_wait = 0; m_res = 4'd0; m_flags = 4'd0;
    m_last_res = 4'd0; m_sticky = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_result"}, bus.result, 32'd0);
    check_val({tag, "_flags"}, bus.flags, 32'd0);
    check_val({tag, "_out_valid"}, bus.out_valid, 32'd0);
    check_val({tag, "_sticky"}, bus.sticky_v, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    model_reset();
    bus.in_valid = 1'b0; bus.aluc = 3'd0; bus.a = 4'd0; bus.b = 4'd0;
    bus.out_ready = 1'b0; bus.clr_sticky = 1'b0;
    rst = 1'b1;
    #12;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD overflow sets sticky; clear pulse drops it.
    step(1'b1, ADD, 4'b0111, 4'b0001, 1'b0, 1'b0);
    check_val("add_result", bus.result, 32'b1000);
    check_val("add_flags", bus.flags, 32'b1001);
    check_val("add_sticky", bus.sticky_v, 32'd1);
    step(1'b0, ADD, 4'd0, 4'd0, 1'b1, 1'b1);
    check_val("sticky_clr", bus.sticky_v, 32'd0);

    // SUB, CMP (result unchanged), SLT.
    step(1'b1, SUB, 4'b0011, 4'b0011, 1'b1, 1'b0);
    check_val("sub_result", bus.result, 32'b0000);
    check_val("sub_flags", bus.flags, 32'b0110);
    step(1'b1, CMP, 4'b0010, 4'b0101, 1'b1, 1'b0);
    check_val("cmp_result", bus.result, 32'b0000);
    check_val("cmp_flags", bus.flags, 32'b1000);
    step(1'b1, SLT, 4'b1110, 4'b0001, 1'b1, 1'b0);
    check_val("slt_result", bus.result, 32'b0001);

    // MUL latency and carry; IN_READY low while multiplying.
    step(1'b1, MUL, 4'b0101, 4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      check_val("mul_busy_ready", bus.in_ready, 32'd0);
      step(1'b1, ADD, 4'd1, 4'd1, 1'b0, 1'b0);
    end
    check_val("mul5x3_valid", bus.out_valid, 32'd1);
    check_val("mul5x3_result", bus.result, 32'b1111);
    check_val("mul5x3_c", bus.flags[1], 32'd0);
    step(1'b1, MUL, 4'b0110, 4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) step(1'b0, ADD, 4'd0, 4'd0, 1'b0, 1'b0);
    check_val("mul6x3_result", bus.result, 32'b0010);
    check_val("mul6x3_c", bus.flags[1], 32'd1);

    // Backpressure with pending input, then same-edge handoff.
    for (int i = 0; i < 3; i++) step(1'b1, ADD, 4'd3, 4'd3, 1'b0, 1'b0);
    check_val("bp_result", bus.result, 32'b0010);
    step(1'b1, XOR_, 4'b1010, 4'b0110, 1'b1, 1'b0);
    check_val("handoff_result", bus.result, 32'b1100);
    check_val("handoff_valid", bus.out_valid, 32'd1);

    // Streaming ADDs, one per cycle.
    for (int i = 0; i < 4; i++) step(1'b1, ADD, 4'(i), 4'(i + 1), 1'b1, 1'b0);
    step(1'b0, ADD, 4'd0, 4'd0, 1'b1, 1'b0);

    // Async reset during MUL step 2, after building a sticky flag.
    step(1'b1, ADD, 4'b0111, 4'b0111, 1'b1, 1'b0);
    step(1'b1, MUL, 4'd7, 4'd3, 1'b1, 1'b0);
    step(1'b0, ADD, 4'd0, 4'd0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    check_val("async_rst_ready", bus.in_ready, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step(1'b1, ADD, 4'b0001, 4'b0001, 1'b1, 1'b0);
    check_val("post_rst_add", bus.result, 32'b0010);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < N + 2; i++) step(1'b0, ADD, 4'd0, 4'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor to the team's combinational N-bit ALU.
- Widens the opcode to 3 bits. Adds XOR, signed set-less-than, compare and an iterative shift-add multiplier.
- Adds valid/ready flow control on input and output, plus a sticky overflow flag.
- Sits between operand-fetch logic and a result consumer that may stall.

Parameters:
- N, 4, operand/result width in bits (4 for bench convenience; product builds use 32).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- A  input  N  operand A.
- B  input  N  operand B.
- ALUC  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 MUL, 111 CMP.
- IN_VALID  input  1  A/B/ALUC valid.
- IN_READY  output  1  block can accept an operation this cycle.
- RESULT  output  N  registered result.
- FLAGS  output  4  registered {NEGATIVE, ZERO, CARRY, OVERFLOW}.
- OUT_VALID  output  1  RESULT/FLAGS valid.
- OUT_READY  input  1  consumer takes the result.
- STICKY_V  output  1  OR of OVERFLOW over all completed ops since reset/clear.
- CLR_STICKY  input  1  synchronous clear of STICKY_V.

Behaviour:
- Reset (async, any state): state=IDLE, RESULT=0, FLAGS=0000, OUT_VALID=0, STICKY_V=0, multiplier registers=0. An in-flight op is discarded; no output is produced for it.
- States: IDLE, MUL, HOLD.
- IN_READY = (state==IDLE) | (state==HOLD & OUT_READY). This is combinational and allows back-to-back ops at one per cycle.
- Accept = IN_VALID & IN_READY. A, B and ALUC are captured at the accept edge; later input changes are ignored.
- Non-MUL op accepted: result and flags are registered at the accept edge, state→HOLD, OUT_VALID=1. Latency is 1 cycle.
- MUL accepted: operands are latched, counter=0, accumulator=0, state→MUL.
  - One partial-product step per cycle, LSB first, over a 2N-bit accumulator.
  - After N steps: RESULT=product[N-1:0], state→HOLD, OUT_VALID=1. Latency is N+1 edges from accept to OUT_VALID.
  - IN_READY=0 throughout MUL.
- HOLD:
  - RESULT, FLAGS and OUT_VALID are stable until OUT_READY=1.
  - On OUT_READY with no accept: state→IDLE, OUT_VALID=0.
  - On OUT_READY with simultaneous accept: the new op is taken and the old result retires in the same edge.
  - If the new op is non-MUL, OUT_VALID stays 1 with new data. If it is MUL, state→MUL and OUT_VALID=0.
- Arithmetic (N+1-bit sum; SUB = A + ~B + 1):
  - ADD/SUB: C = sum[N] (for SUB, 1 = no borrow). V = signed overflow: same-sign operands (after B inversion for SUB) giving a different-sign result.
  - CMP: performs SUB and sets all four flags from the subtraction. RESULT is not updated and keeps its previous value.
  - SLT: RESULT = {0..0, (sub_neg XOR sub_V)}, a signed comparison. C and V come from the internal subtraction; N and Z come from RESULT.
  - AND/OR/XOR: C=0, V=0.
  - MUL: unsigned product. C = |product[2N-1:N]; V=0.
- NEGATIVE = RESULT[N-1] and ZERO = (RESULT==0) for all ops except CMP, where they are taken from the subtraction value.
- STICKY_V:
  - Set on the edge a result with OVERFLOW=1 enters HOLD.
  - CLR_STICKY clears it. If clear and set occur on the same edge, set wins.
  - Unaffected by backpressure.
- Unused ALUC codes: none; all 8 are defined.

Test Plan:
- N=4, ADD A=0111 B=0001 → 1 cycle later OUT_VALID=1, RESULT=1000, FLAGS=1001, STICKY_V=1; CLR_STICKY pulse → STICKY_V=0.
- SUB A=0011 B=0011 → RESULT=0000, FLAGS=0110. Then CMP A=0010 B=0101 → RESULT stays 0000, FLAGS=1000. Then SLT A=1110 B=0001 → RESULT=0001.
- MUL A=0101 B=0011 → OUT_VALID rises exactly 5 edges after accept, RESULT=1111, C=0, IN_READY=0 during MUL. MUL A=0110 B=0011 → RESULT=0010, C=1.
- Backpressure: OUT_READY=0 for 3 cycles after a result → RESULT/FLAGS constant and IN_READY=0. Raise OUT_READY with IN_VALID=1 (XOR 1010^0110) → same-edge handoff, RESULT=1100, OUT_VALID stays 1.
- Streaming: IN_VALID=1, OUT_READY=1 with 4 consecutive ADDs → one result per cycle, in order, none dropped or duplicated.
- Assert RESET on step 2 of a MUL → all outputs 0 immediately (async), state IDLE. After deassert, a fresh ADD 0001+0001 yields RESULT=0010.
